// File: rtl/apm_pkg.sv
// Shared widths, mode-bit positions and operand extension helpers for the
// pre-adder / multiplier / post-adder slice.
package apm_pkg;
  localparam int X_W   = 25;
  localparam int XB_W  = 24;
  localparam int Y_W   = 17;
  localparam int Z_W   = 48;
  localparam int PRE_W = 27;
  localparam int YE_W  = 18;
  localparam int M_W   = 45;
  localparam int P_W   = 48;
  localparam int MI_W  = 5;
  localparam int MZ_W  = 2;

  localparam int MI_SUB  = 0;
  localparam int MI_PRE  = 1;
  localparam int MI_XSGN = 2;
  localparam int MI_YSGN = 3;
  localparam int MI_NEG  = 4;
  localparam int MZ_SUB  = 0;
  localparam int MZ_ACC  = 1;

  function automatic logic [PRE_W-1:0] ext_x(input logic [X_W-1:0] v, input logic sgn);
    return sgn ? {{(PRE_W-X_W){v[X_W-1]}}, v} : {{(PRE_W-X_W){1'b0}}, v};
  endfunction

  function automatic logic [PRE_W-1:0] ext_xb(input logic [XB_W-1:0] v, input logic sgn);
    return sgn ? {{(PRE_W-XB_W){v[XB_W-1]}}, v} : {{(PRE_W-XB_W){1'b0}}, v};
  endfunction

  function automatic logic [YE_W-1:0] ext_y(input logic [Y_W-1:0] v, input logic sgn);
    return sgn ? {{(YE_W-Y_W){v[Y_W-1]}}, v} : {{(YE_W-Y_W){1'b0}}, v};
  endfunction
endpackage

// File: rtl/apm_preadd_mult_if.sv
// Operand, mode, clock-enable and result bundle of the arithmetic slice.
interface apm_preadd_mult_if;
  import apm_pkg::*;
  logic [X_W-1:0]  i_x;
  logic [XB_W-1:0] i_xb;
  logic [Y_W-1:0]  i_y;
  logic [Z_W-1:0]  i_z;
  logic [MI_W-1:0] i_modein;
  logic [MZ_W-1:0] i_modez;
  logic            i_cex, i_cexb, i_cey, i_cez, i_cepre, i_cem, i_cep;
  logic [P_W-1:0]  o_p;

  modport master (output i_x, i_xb, i_y, i_z, i_modein, i_modez,
                  output i_cex, i_cexb, i_cey, i_cez, i_cepre, i_cem, i_cep,
                  input  o_p);
  modport slave  (input  i_x, i_xb, i_y, i_z, i_modein, i_modez,
                  input  i_cex, i_cexb, i_cey, i_cez, i_cepre, i_cem, i_cep,
                  output o_p);
endinterface

// File: rtl/apm_pipe_reg.sv
// Optional pipeline register: clock-enabled with async clear when EN=1,
// a plain wire when EN=0.
module apm_pipe_reg #(
  parameter int W  = 1,
  parameter bit EN = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  if (EN) begin : g_reg
    logic [W-1:0] r_q;
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst)     r_q <= '0;
      else if (i_ce) r_q <= i_d;
    assign o_q = r_q;
  end else begin : g_wire
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst, i_ce};
    assign o_q      = i_d;
  end
endmodule

// File: rtl/apm_preadd_mult.sv
// DSP slice: optional pre-adder (X +/- XB) times Y, optional negate, optional
// post-adder against Z or the P feedback. Every stage register is optional.
module apm_preadd_mult
  import apm_pkg::*;
#(
  parameter bit USE_PREADD  = 1'b1,
  parameter bit USE_POSTADD = 1'b0,
  parameter bit PREADD_REG  = 1'b0,
  parameter bit X_REG       = 1'b0,
  parameter bit XB_REG      = 1'b0,
  parameter bit Y_REG       = 1'b0,
  parameter bit Z_REG       = 1'b0,
  parameter bit MULT_REG    = 1'b0,
  parameter bit P_REG       = 1'b0,
  parameter bit MODE_REG    = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  apm_preadd_mult_if.slave io
);
  logic [MI_W+MZ_W-1:0] w_mode;
  logic [MI_W-1:0]      w_mi;
  logic [MZ_W-1:0]      w_mz;
  logic [X_W-1:0]       w_x;
  logic [XB_W-1:0]      w_xb;
  logic [Y_W-1:0]       w_y;
  logic [PRE_W-1:0]     w_x27, w_xb27, w_pre, w_pre_q;
  logic [YE_W-1:0]      w_y18, w_y18_q;
  logic [M_W-1:0]       w_prod;
  logic [P_W-1:0]       w_m48, w_mn, w_m_q, w_z, w_zsel, w_post, w_p;
  logic                 w_use_pre;
  logic                 w_unused_mz;

  apm_pipe_reg #(.W(MI_W+MZ_W), .EN(MODE_REG)) u_mode_reg (.i_clk, .i_rst, .i_ce(1'b1),
    .i_d({io.i_modein, io.i_modez}), .o_q(w_mode));
  assign w_mi = w_mode[MI_W+MZ_W-1:MZ_W];
  assign w_mz = w_mode[MZ_W-1:0];
  assign w_unused_mz = ^w_mz;

  apm_pipe_reg #(.W(X_W),  .EN(X_REG))  u_x_reg  (.i_clk, .i_rst, .i_ce(io.i_cex),  .i_d(io.i_x),  .o_q(w_x));
  apm_pipe_reg #(.W(XB_W), .EN(XB_REG)) u_xb_reg (.i_clk, .i_rst, .i_ce(io.i_cexb), .i_d(io.i_xb), .o_q(w_xb));
  apm_pipe_reg #(.W(Y_W),  .EN(Y_REG))  u_y_reg  (.i_clk, .i_rst, .i_ce(io.i_cey),  .i_d(io.i_y),  .o_q(w_y));
  apm_pipe_reg #(.W(Z_W),  .EN(Z_REG))  u_z_reg  (.i_clk, .i_rst, .i_ce(io.i_cez),  .i_d(io.i_z),  .o_q(w_z));

  assign w_x27     = ext_x(w_x, w_mi[MI_XSGN]);
  assign w_xb27    = ext_xb(w_xb, w_mi[MI_XSGN]);
  assign w_y18     = ext_y(w_y, w_mi[MI_YSGN]);
  assign w_use_pre = USE_PREADD & w_mi[MI_PRE];

  // 27 bits hold any sum/difference of the extended 25/24-bit operands.
  always_comb begin
    w_pre = w_x27;
    if (w_use_pre) w_pre = w_mi[MI_SUB] ? (w_x27 - w_xb27) : (w_x27 + w_xb27);
  end

  // Y rides alongside the pre-adder register so both multiplier inputs stay aligned.
  apm_pipe_reg #(.W(PRE_W), .EN(PREADD_REG)) u_pre_reg (.i_clk, .i_rst, .i_ce(io.i_cepre), .i_d(w_pre), .o_q(w_pre_q));
  apm_pipe_reg #(.W(YE_W),  .EN(PREADD_REG)) u_yd_reg  (.i_clk, .i_rst, .i_ce(io.i_cepre), .i_d(w_y18), .o_q(w_y18_q));

  // Sign-extending both factors to the product width makes the unsigned
  // multiply equal the signed product modulo 2^45.
  assign w_prod = {{(M_W-PRE_W){w_pre_q[PRE_W-1]}}, w_pre_q} *
                  {{(M_W-YE_W){w_y18_q[YE_W-1]}}, w_y18_q};
  assign w_m48  = {{(P_W-M_W){w_prod[M_W-1]}}, w_prod};
  assign w_mn   = w_mi[MI_NEG] ? (-w_m48) : w_m48;

  apm_pipe_reg #(.W(P_W), .EN(MULT_REG)) u_m_reg (.i_clk, .i_rst, .i_ce(io.i_cem), .i_d(w_mn), .o_q(w_m_q));

  // Feedback exists only behind the P register; without it Z is the only source.
  if (P_REG) begin : g_fb
    assign w_zsel = w_mz[MZ_ACC] ? w_p : w_z;
  end else begin : g_nofb
    assign w_zsel = w_z;
  end

  always_comb begin
    w_post = w_m_q;
    if (USE_POSTADD) w_post = w_mz[MZ_SUB] ? (w_m_q - w_zsel) : (w_m_q + w_zsel);
  end

  apm_pipe_reg #(.W(P_W), .EN(P_REG)) u_p_reg (.i_clk, .i_rst, .i_ce(io.i_cep), .i_d(w_post), .o_q(w_p));
  assign io.o_p = w_p;
endmodule

// File: tb/tb_apm_preadd_mult.sv
// Scoreboard bench: three slice configurations (combinational, fully
// pipelined, registered accumulator) checked against an arithmetic model.
module tb_apm_preadd_mult;
  import apm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apm_preadd_mult_if if_c ();
  apm_preadd_mult_if if_p ();
  apm_preadd_mult_if if_a ();

  apm_preadd_mult u_comb (.i_clk(clk), .i_rst(rst), .io(if_c));
  apm_preadd_mult #(.X_REG(1), .XB_REG(1), .Y_REG(1), .Z_REG(1), .PREADD_REG(1),
                    .MULT_REG(1), .P_REG(1)) u_pipe (.i_clk(clk), .i_rst(rst), .io(if_p));
  apm_preadd_mult #(.USE_POSTADD(1), .P_REG(1)) u_acc (.i_clk(clk), .i_rst(rst), .io(if_a));

  typedef struct {
    int          due;
    logic [47:0] p;
    string       tag;
  } exp_t;
  exp_t q_c[$], q_p[$], q_a[$];

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the extension/pre-add/multiply rules.
  function automatic logic [47:0] ref_m(input logic [24:0] x, input logic [23:0] xb,
                                        input logic [16:0] y, input logic [4:0] mi);
    longint xv, xbv, yv, pre, m;
    xv  = mi[2] ? longint'($signed(x))  : longint'(x);
    xbv = mi[2] ? longint'($signed(xb)) : longint'(xb);
    yv  = mi[3] ? longint'($signed(y))  : longint'(y);
    pre = mi[1] ? (mi[0] ? xv - xbv : xv + xbv) : xv;
    m   = pre * yv;
    if (mi[4]) m = -m;
    return m[47:0];
  endfunction

  function automatic logic [47:0] ref_post(input logic [47:0] m, input logic [47:0] z,
                                           input logic [1:0] mz, input logic [47:0] pprev);
    logic [47:0] sel;
    sel = mz[1] ? pprev : z;
    return mz[0] ? m - sel : m + sel;
  endfunction

  // Monitor: compares whatever expectation falls due on this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q_c.size() != 0 && q_c[0].due <= cyc) begin
      e = q_c.pop_front();
      chk({"comb ", e.tag}, (e.due == cyc) ? if_c.o_p : 48'hx, e.p);
    end
    if (q_p.size() != 0 && q_p[0].due <= cyc) begin
      e = q_p.pop_front();
      chk({"pipe ", e.tag}, (e.due == cyc) ? if_p.o_p : 48'hx, e.p);
    end
    if (q_a.size() != 0 && q_a[0].due <= cyc) begin
      e = q_a.pop_front();
      chk({"acc ", e.tag}, (e.due == cyc) ? if_a.o_p : 48'hx, e.p);
    end
  end

  task automatic set_ce(input logic v);
    {if_c.i_cex, if_c.i_cexb, if_c.i_cey, if_c.i_cez, if_c.i_cepre, if_c.i_cem, if_c.i_cep} = {7{v}};
    {if_p.i_cex, if_p.i_cexb, if_p.i_cey, if_p.i_cez, if_p.i_cepre, if_p.i_cem, if_p.i_cep} = {7{v}};
    {if_a.i_cex, if_a.i_cexb, if_a.i_cey, if_a.i_cez, if_a.i_cepre, if_a.i_cem, if_a.i_cep} = {7{v}};
  endtask

  task automatic comb_vec(input string tag, input logic [24:0] x, input logic [23:0] xb,
                          input logic [16:0] y, input logic [4:0] mi, input logic [47:0] exp);
    if_c.i_x = x; if_c.i_xb = xb; if_c.i_y = y; if_c.i_modein = mi;
    q_c.push_back('{cyc, exp, tag});
    @(posedge clk); #1;
  endtask

  // Constant operands from reset; stall_at selects the edge with CEM low (0 = none).
  task automatic pipe_lat(input int stall_at);
    logic [47:0] vec;
    int          lat;
    vec = 48'h0007_3FA0_C7F9;
    lat = (stall_at != 0) ? 5 : 4;
    @(posedge clk); #1;
    rst = 1'b1;
    if_p.i_x = 25'h0800000; if_p.i_xb = 24'h41070D; if_p.i_y = 17'h099D;
    if_p.i_modein = 5'b01110;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if_p.i_cem = (i != stall_at);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("pipe latency stall=%0d edge=%0d", stall_at, i), if_p.o_p,
          (i >= lat) ? vec : 48'h0);
    end
    if_p.i_cem = 1'b1;
  endtask

  initial begin
    logic [24:0] x;
    logic [23:0] xb;
    logic [16:0] y;
    logic [47:0] z, pm, m;
    logic [4:0]  mi;
    logic [1:0]  mz;

    set_ce(1'b1);
    if_c.i_x = '0; if_c.i_xb = '0; if_c.i_y = '0; if_c.i_z = '0; if_c.i_modein = '0; if_c.i_modez = '0;
    if_p.i_x = '0; if_p.i_xb = '0; if_p.i_y = '0; if_p.i_z = '0; if_p.i_modein = '0; if_p.i_modez = '0;
    if_a.i_x = '0; if_a.i_xb = '0; if_a.i_y = '0; if_a.i_z = '0; if_a.i_modein = '0; if_a.i_modez = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pipe P", if_p.o_p, 48'h0);
    chk("reset acc P", if_a.o_p, 48'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Combinational default slice: directed corners, then random modes.
    comb_vec("preadd", 25'h0800000, 24'h41070D, 17'h099D, 5'b01110, 48'h0007_3FA0_C7F9);
    comb_vec("presub", 25'h0800000, 24'h41070D, 17'h099D, 5'b01111, 48'h0002_5D5F_3807);
    comb_vec("signed", 25'h1FFFFFF, 24'h000000, 17'h00002, 5'b01110, 48'hFFFF_FFFF_FFFE);
    comb_vec("negate", 25'h1FFFFFF, 24'h000000, 17'h00002, 5'b11110, 48'h0000_0000_0002);
    comb_vec("unsigned max", 25'h1FFFFFF, 24'hFFFFFF, 17'h1FFFF, 5'b00010, 48'h05FF_FCFC_0002);
    for (int i = 0; i < 30; i++) begin
      x = 25'($urandom); xb = 24'($urandom); y = 17'($urandom); mi = 5'($urandom);
      comb_vec($sformatf("rand %0d", i), x, xb, y, mi, ref_m(x, xb, y, mi));
    end

    // Full pipeline latency, with and without a one-cycle CEM drop.
    pipe_lat(0);
    pipe_lat(3);

    // Pipelined random streams, mode held per batch and flushed between batches.
    for (int b = 0; b < 4; b++) begin
      if_p.i_modein = 5'($urandom);
      for (int i = 0; i < 15; i++) begin
        if_p.i_x = 25'($urandom); if_p.i_xb = 24'($urandom); if_p.i_y = 17'($urandom);
        q_p.push_back('{cyc + 4, ref_m(if_p.i_x, if_p.i_xb, if_p.i_y, if_p.i_modein),
                       $sformatf("batch %0d item %0d", b, i)});
        @(posedge clk); #1;
      end
      repeat (5) @(posedge clk);
      #1;
    end

    // Accumulator: count by one from reset, then random Z/mode/CEP traffic.
    rst = 1'b1;
    if_a.i_x = 25'd1; if_a.i_xb = '0; if_a.i_y = 17'd1; if_a.i_z = '0;
    if_a.i_modein = 5'b01110; if_a.i_modez = 2'b10;
    @(posedge clk); #1;
    rst = 1'b0;
    pm = '0;
    for (int i = 0; i < 8; i++) begin
      pm = pm + 48'd1;
      q_a.push_back('{cyc + 1, pm, $sformatf("count %0d", i)});
      @(posedge clk); #1;
    end
    for (int i = 0; i < 20; i++) begin
      x = 25'($urandom); xb = 24'($urandom); y = 17'($urandom); mi = 5'($urandom);
      z = {16'($urandom), 32'($urandom)}; mz = 2'($urandom);
      if_a.i_x = x; if_a.i_xb = xb; if_a.i_y = y; if_a.i_modein = mi;
      if_a.i_z = z; if_a.i_modez = mz; if_a.i_cep = ($urandom_range(0, 3) != 0);
      m = ref_m(x, xb, y, mi);
      if (if_a.i_cep) pm = ref_post(m, z, mz, pm);
      q_a.push_back('{cyc + 1, pm, $sformatf("rand %0d", i)});
      @(posedge clk); #1;
    end
    if_a.i_cep = 1'b1;

    // Asynchronous reset mid-cycle clears registered outputs without an edge.
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async reset acc P", if_a.o_p, 48'h0);
    chk("async reset pipe P", if_p.o_p, 48'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q_c.size() + q_p.size() + q_a.size() != 0) begin
      errs++;
      $display("FAIL scoreboard drain: %0d expectations left, 0 required",
               q_c.size() + q_p.size() + q_a.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1);
  end
endmodule
